// File: rtl/pacman_dot_pkg.sv
// Shared types and constants for the dot manager: FSM states, score width
// and the maze dot origin table (top-left pixel of each dot square).
package pacman_dot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dot_state_t;

  localparam int SCORE_W = 16;
  localparam int COORD_W = 10;

  // Row-major 8-wide grid on a 20-pixel pitch; entry 31 sits apart in the corner.
  localparam logic [COORD_W-1:0] DOT_X [0:63] = '{
    10'd40, 10'd60, 10'd80, 10'd100, 10'd120, 10'd140, 10'd160, 10'd180,
    10'd40, 10'd60, 10'd80, 10'd100, 10'd120, 10'd140, 10'd160, 10'd180,
    10'd40, 10'd60, 10'd80, 10'd100, 10'd120, 10'd140, 10'd160, 10'd180,
    10'd40, 10'd60, 10'd80, 10'd100, 10'd120, 10'd140, 10'd160, 10'd200,
    10'd40, 10'd60, 10'd80, 10'd100, 10'd120, 10'd140, 10'd160, 10'd180,
    10'd40, 10'd60, 10'd80, 10'd100, 10'd120, 10'd140, 10'd160, 10'd180,
    10'd40, 10'd60, 10'd80, 10'd100, 10'd120, 10'd140, 10'd160, 10'd180,
    10'd40, 10'd60, 10'd80, 10'd100, 10'd120, 10'd140, 10'd160, 10'd180
  };

  localparam logic [COORD_W-1:0] DOT_Y [0:63] = '{
    10'd40,  10'd40,  10'd40,  10'd40,  10'd40,  10'd40,  10'd40,  10'd40,
    10'd60,  10'd60,  10'd60,  10'd60,  10'd60,  10'd60,  10'd60,  10'd60,
    10'd80,  10'd80,  10'd80,  10'd80,  10'd80,  10'd80,  10'd80,  10'd80,
    10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd180,
    10'd120, 10'd120, 10'd120, 10'd120, 10'd120, 10'd120, 10'd120, 10'd120,
    10'd140, 10'd140, 10'd140, 10'd140, 10'd140, 10'd140, 10'd140, 10'd140,
    10'd160, 10'd160, 10'd160, 10'd160, 10'd160, 10'd160, 10'd160, 10'd160,
    10'd180, 10'd180, 10'd180, 10'd180, 10'd180, 10'd180, 10'd180, 10'd180
  };

endpackage

// File: rtl/dot_hit_check.sv
// Combinational proximity test: hit when both per-axis distances between the
// Pac-Man centre and the dot origin are within radius (inclusive).
module dot_hit_check
  import pacman_dot_pkg::*;
(
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] dot_x,
  input  logic [COORD_W-1:0] dot_y,
  input  logic [COORD_W-1:0] radius,
  output logic               hit
);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;

  // max - min keeps the unsigned subtraction from wrapping
  always_comb begin
    dx  = (cx >= dot_x) ? (cx - dot_x) : (dot_x - cx);
    dy  = (cy >= dot_y) ? (cy - dot_y) : (dot_y - cy);
    hit = (dx <= radius) && (dy <= radius);
  end

endmodule

// File: rtl/dot_manager.sv
// Per-frame dot scanner: latches Pac-Man's centre, walks the dot table one
// entry per cycle, eats reached dots, keeps score/count and feeds the draw path.
module dot_manager
  import pacman_dot_pkg::*;
#(
  parameter int  NUM_DOTS      = 32,
  parameter int  DOT_SIZE      = 4,
  parameter int  HIT_RADIUS    = 5,
  parameter int  PAC_OFFSET    = 5,
  parameter int  SCORE_PER_DOT = 10,
  localparam int CNT_W         = $clog2(NUM_DOTS + 1)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_start,
  input  logic                level_restart,
  input  logic [7:0]          pac_mem_start_X,
  input  logic [7:0]          pac_mem_start_Y,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  output logic                dot_pixel,
  output logic [NUM_DOTS-1:0] eaten_mask,
  output logic [CNT_W-1:0]    dots_left,
  output logic [SCORE_W-1:0]  score,
  output logic                eat_pulse,
  output logic                scan_done,
  output logic                level_clear,
  output logic                busy,
  output dot_state_t          dbg_state
);

  // Control protocol: frame_start and level_restart are single-cycle request
  // pulses with no ready; frame_start is only honoured in IDLE and is never
  // queued, level_restart is always honoured. eat_pulse/scan_done are
  // single-cycle event strobes registered on the edge the event happens.

  localparam int IDX_W = $clog2(NUM_DOTS);
  localparam int SUM_W = SCORE_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOTS - 1);

  dot_state_t         state;
  dot_state_t         state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [8:0]         cx_q;
  logic [8:0]         cy_q;
  logic [5:0]         tbl_idx;
  logic               hit;
  logic               eat_now;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_nxt;

  assign tbl_idx = 6'(idx);

  dot_hit_check u_hit (
    .cx     ({1'b0, cx_q}),
    .cy     ({1'b0, cy_q}),
    .dot_x  (DOT_X[tbl_idx]),
    .dot_y  (DOT_Y[tbl_idx]),
    .radius (COORD_W'(HIT_RADIUS)),
    .hit    (hit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = SCAN;
      SCAN:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (level_restart) state_nxt = IDLE;
  end

  // A restart in the same cycle discards the eat.
  assign eat_now   = (state == SCAN) && hit && !eaten_mask[idx] && !level_restart;
  assign score_sum = {1'b0, score} + SUM_W'(SCORE_PER_DOT);
  assign score_nxt = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      idx       <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      eat_pulse <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      eat_pulse <= eat_now;
      scan_done <= (state == DONE) && !level_restart;
      if (level_restart) begin
        idx <= '0;
      end else if ((state == IDLE) && frame_start) begin
        cx_q <= {1'b0, pac_mem_start_X} + 9'(PAC_OFFSET);
        cy_q <= {1'b0, pac_mem_start_Y} + 9'(PAC_OFFSET);
        idx  <= '0;
      end else if ((state == SCAN) && (idx != LAST_IDX)) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      eaten_mask  <= '0;
      dots_left   <= CNT_W'(NUM_DOTS);
      score       <= '0;
      level_clear <= 1'b0;
    end else if (level_restart) begin
      eaten_mask  <= '0;
      dots_left   <= CNT_W'(NUM_DOTS);
      level_clear <= 1'b0;
    end else begin
      if (eat_now) begin
        eaten_mask[idx] <= 1'b1;
        dots_left       <= dots_left - 1'b1;
        score           <= score_nxt;
      end
      if ((state == DONE) && (dots_left == '0)) level_clear <= 1'b1;
    end
  end

  assign busy      = (state == SCAN);
  assign dbg_state = state;

  // Draw path: one box compare per dot against the registered mask.
  logic [NUM_DOTS-1:0] on_dot;

  for (genvar i = 0; i < NUM_DOTS; i++) begin : g_draw
    localparam logic [10:0] X_LO = {1'b0, DOT_X[i]};
    localparam logic [10:0] Y_LO = {1'b0, DOT_Y[i]};
    localparam logic [10:0] X_HI = X_LO + 11'(DOT_SIZE - 1);
    localparam logic [10:0] Y_HI = Y_LO + 11'(DOT_SIZE - 1);
    assign on_dot[i] = !eaten_mask[i]
                     && ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} <= X_HI)
                     && ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} <= Y_HI);
  end

  assign dot_pixel = |on_dot;

endmodule

// File: tb/tb_dot_manager.sv
// Bench for dot_manager: a frame-level behavioural model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_dot_manager;
  import pacman_dot_pkg::*;

  localparam int N = 32;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         frame_start = 1'b0;
  logic         level_restart = 1'b0;
  logic [7:0]   pac_mem_start_X = '0;
  logic [7:0]   pac_mem_start_Y = '0;
  logic [9:0]   DrawX = '0;
  logic [9:0]   DrawY = '0;
  logic         dot_pixel;
  logic [N-1:0] eaten_mask;
  logic [5:0]   dots_left;
  logic [15:0]  score;
  logic         eat_pulse;
  logic         scan_done;
  logic         level_clear;
  logic         busy;
  dot_state_t   dbg_state;

  dot_manager dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_start     (frame_start),
    .level_restart   (level_restart),
    .pac_mem_start_X (pac_mem_start_X),
    .pac_mem_start_Y (pac_mem_start_Y),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .dot_pixel       (dot_pixel),
    .eaten_mask      (eaten_mask),
    .dots_left       (dots_left),
    .score           (score),
    .eat_pulse       (eat_pulse),
    .scan_done       (scan_done),
    .level_clear     (level_clear),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eat_cnt = 0;
  int done_cnt = 0;
  int preload_seq = 0;
  bit hold = 1'b0;
  int hx = 0;
  int hy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_eaten[N];
  int m_score;
  bit m_clear, m_scan, m_eat, m_done;
  int m_pos, m_cx, m_cy;
  int preload_seen = 0;

  function automatic int m_left();
    int n = 0;
    for (int i = 0; i < N; i++) if (!m_eaten[i]) n++;
    return n;
  endfunction

  function automatic bit m_hit(input int i);
    int dx = m_cx - int'(DOT_X[i]);
    int dy = m_cy - int'(DOT_Y[i]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= 5) && (dy <= 5);
  endfunction

  function automatic bit m_pix(input int x, input int y);
    for (int i = 0; i < N; i++)
      if (!m_eaten[i] && x >= int'(DOT_X[i]) && x <= int'(DOT_X[i]) + 3 &&
          y >= int'(DOT_Y[i]) && y <= int'(DOT_Y[i]) + 3) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge Clk or negedge Reset);
      m_eat = 1'b0;
      m_done = 1'b0;
      if (!Reset) begin
        for (int i = 0; i < N; i++) m_eaten[i] = 1'b0;
        m_score = 0;
        m_clear = 1'b0;
        m_scan = 1'b0;
        m_pos = 0;
      end else begin
        if (preload_seq != preload_seen) begin
          preload_seen = preload_seq;
          m_score = 'hFFF8;
        end
        if (level_restart) begin
          for (int i = 0; i < N; i++) m_eaten[i] = 1'b0;
          m_clear = 1'b0;
          m_scan = 1'b0;
        end else if (m_scan) begin
          if (m_pos < N) begin
            if (m_hit(m_pos) && !m_eaten[m_pos]) begin
              m_eaten[m_pos] = 1'b1;
              m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
              m_eat = 1'b1;
            end
            m_pos++;
          end else begin
            m_done = 1'b1;
            if (m_left() == 0) m_clear = 1'b1;
            m_scan = 1'b0;
          end
        end else if (frame_start) begin
          m_scan = 1'b1;
          m_pos = 0;
          m_cx = int'(pac_mem_start_X) + 5;
          m_cy = int'(pac_mem_start_Y) + 5;
        end
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  initial begin
    logic [N-1:0] mm;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) mm[i] = m_eaten[i];
      chk("eat_pulse", eat_pulse, m_eat);
      chk("scan_done", scan_done, m_done);
      chk("busy", busy, m_scan && (m_pos < N));
      chk("level_clear", level_clear, m_clear);
      chk("eaten_mask", eaten_mask, mm);
      chk("dots_left", dots_left, m_left());
      chk("score", score, m_score);
      chk("dot_pixel", dot_pixel, m_pix(int'(DrawX), int'(DrawY)));
      if (eat_pulse) eat_cnt++;
      if (scan_done) done_cnt++;
    end
  end

  // Draw coordinate driver: a sweeping pattern unless a test pins a pixel.
  initial begin
    forever begin
      @(posedge Clk);
      #3;
      if (hold) begin
        DrawX = 10'(hx);
        DrawY = 10'(hy);
      end else begin
        DrawX = 10'(38 + (cyc * 7) % 170);
        DrawY = 10'(38 + (cyc * 11) % 80);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int start, output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge Clk);
      #1;
      if (scan_done) begin
        lat = cyc - start;
        break;
      end
    end
    if (lat < 0) chk("scan_done_timeout", 0, 1);
    @(negedge Clk);
  endtask

  task automatic do_frame(input int x, input int y, output int lat);
    int start;
    @(negedge Clk);
    pac_mem_start_X = 8'(x);
    pac_mem_start_Y = 8'(y);
    frame_start = 1'b1;
    start = cyc;
    @(negedge Clk);
    frame_start = 1'b0;
    pac_mem_start_X = 8'hA5;
    pac_mem_start_Y = 8'h5A;
    wait_done(start, lat);
  endtask

  task automatic pin_pixel(input int x, input int y);
    hold = 1'b1;
    hx = x;
    hy = y;
    @(posedge Clk);
    #5;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lat, e0, d0;
    repeat (3) @(negedge Clk);
    chk("rst_score", score, 0);
    chk("rst_mask", eaten_mask, 0);
    chk("rst_dots_left", dots_left, 32);
    chk("rst_flags", {eat_pulse, scan_done, level_clear, busy}, 0);
    chk("rst_state", dbg_state, IDLE);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // First frame eats dot 0
    e0 = eat_cnt;
    do_frame(35, 35, lat);
    chk("lat_first", lat, 34);
    chk("eats_first", eat_cnt - e0, 1);
    chk("mask_first", eaten_mask, 32'h1);
    chk("score_first", score, 10);
    chk("left_first", dots_left, 31);

    // Same position: nothing re-scores
    e0 = eat_cnt;
    do_frame(35, 35, lat);
    chk("eats_repeat", eat_cnt - e0, 0);
    chk("score_repeat", score, 10);
    pin_pixel(41, 41);
    chk("pix_eaten", dot_pixel, 0);
    pin_pixel(61, 41);
    chk("pix_live", dot_pixel, 1);
    hold = 1'b0;

    // Distance 6 misses, distance 5 hits
    e0 = eat_cnt;
    do_frame(49, 35, lat);
    chk("eats_dist6", eat_cnt - e0, 0);
    do_frame(50, 35, lat);
    chk("eats_dist5", eat_cnt - e0, 1);
    chk("mask_dist5", eaten_mask, 32'h3);
    chk("score_dist5", score, 20);
    pin_pixel(61, 41);
    chk("pix_after_eat", dot_pixel, 0);
    hold = 1'b0;

    // Eat everything else; level_clear only after the last dot
    for (int i = 2; i < N; i++) begin
      if (i == N - 1) chk("clear_before_last", level_clear, 0);
      do_frame(int'(DOT_X[i]) - 5, int'(DOT_Y[i]) - 5, lat);
    end
    chk("clear_set", level_clear, 1);
    chk("left_zero", dots_left, 0);
    chk("score_all", score, 320);
    chk("mask_all", eaten_mask, 32'hFFFF_FFFF);
    e0 = eat_cnt;
    do_frame(35, 35, lat);
    chk("lat_cleared", lat, 34);
    chk("eats_cleared", eat_cnt - e0, 0);
    chk("clear_sticky", level_clear, 1);

    // Restart keeps score
    @(negedge Clk);
    level_restart = 1'b1;
    @(negedge Clk);
    level_restart = 1'b0;
    chk("rs_mask", eaten_mask, 0);
    chk("rs_left", dots_left, 32);
    chk("rs_clear", level_clear, 0);
    chk("rs_score", score, 320);

    // Mid-scan restart at idx 10 while dot 10 is hit; frame_start at idx 5 ignored
    @(negedge Clk);
    pac_mem_start_X = 8'd75;
    pac_mem_start_Y = 8'd55;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (5) @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (4) @(negedge Clk);
    e0 = eat_cnt;
    d0 = done_cnt;
    level_restart = 1'b1;
    frame_start = 1'b1;
    @(negedge Clk);
    level_restart = 1'b0;
    frame_start = 1'b0;
    chk("abort_busy", busy, 0);
    repeat (40) @(negedge Clk);
    chk("abort_eats", eat_cnt - e0, 0);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_mask", eaten_mask, 0);

    // Asynchronous reset mid-scan
    @(negedge Clk);
    pac_mem_start_X = 8'd35;
    pac_mem_start_Y = 8'd35;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (4) @(negedge Clk);
    chk("pre_rst_score", score, 330);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_score", score, 0);
    chk("arst_mask", eaten_mask, 0);
    chk("arst_left", dots_left, 32);
    chk("arst_flags", {eat_pulse, scan_done, level_clear, busy}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Score saturation from a preloaded value
    @(posedge Clk);
    #2;
    force dut.score = 16'hFFF8;
    preload_seq++;
    @(negedge Clk);
    release dut.score;
    do_frame(35, 35, lat);
    chk("sat_first", score, 16'hFFFF);
    e0 = eat_cnt;
    do_frame(50, 35, lat);
    chk("sat_eats", eat_cnt - e0, 1);
    chk("sat_hold", score, 16'hFFFF);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
